// File: rtl/bcd_seg_scanner_pkg.sv
// rtl/bcd_seg_scanner_pkg.sv - shared digit-count helper and 7-segment decode constants
package bcd_seg_scanner_pkg;

    // BCD digits needed to hold a 2n-bit product
    function automatic int digits_for(input int n);
        return ((2 * n) / 3) + 1;
    endfunction

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - one BCD nibble to active-high 7-segment pattern
module bcd_to_seg7
    import bcd_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Digits 0..9 decode normally; any non-BCD nibble shows a dash
    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - captures product BCD on finish rise and scans it onto a muxed 7-segment display
module bcd_seg_scanner
    import bcd_seg_scanner_pkg::*;
#(
    parameter int N            = 5,
    parameter int DIGITS       = digits_for(N),
    parameter int REFRESH_DIV  = 1000,
    parameter bit COMMON_ANODE = 1'b1,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  finish,
    input  logic [DIGITS*4-1:0]   bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  shown
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    // XOR masks turning active-high values into the pin polarity; also the "all off" level
    localparam logic [6:0]        SEG_POL = {7{COMMON_ANODE}};
    localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{COMMON_ANODE}};

    logic                  finish_q;
    logic [DIGITS*4-1:0]   hold_q, hold_d;
    logic                  shown_q, shown_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic                  load;
    logic [3:0]            nibble;
    logic                  blank;
    logic [6:0]            seg_raw;
    logic [6:0]            seg_ah;
    logic [DIGITS-1:0]     an_ah;

    assign load = finish & ~finish_q;

    // Capture on finish rising edge; shown latches on the first capture
    always_comb begin
        hold_d  = hold_q;
        shown_d = shown_q;
        if (load) begin
            hold_d  = bcd;
            shown_d = 1'b1;
        end
    end

    // Prescaler and digit index free-run from reset release
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Pick the current digit and decide blanking by scanning from the top digit down
    always_comb begin
        logic nz_above;
        nibble   = 4'h0;
        blank    = 1'b0;
        nz_above = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_above = nz_above | (|hold_q[k*4 +: 4]);
            if (idx_q == IDX_W'(k)) begin
                nibble = hold_q[k*4 +: 4];
                blank  = BLANK_LZ && (k != 0) && !nz_above;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_o    (seg_raw)
    );

    // Blanked digits keep their enable so every digit gets the same duty cycle
    always_comb begin
        seg_ah = SEG_OFF;
        an_ah  = '0;
        if (shown_q) begin
            an_ah  = DIGITS'(1) << idx_q;
            seg_ah = blank ? SEG_OFF : seg_raw;
        end
        seg_d = seg_ah ^ SEG_POL;
        an_d  = an_ah ^ AN_POL;
    end

    // Edge detector, hold register and shown flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            finish_q <= 1'b0;
            hold_q   <= '0;
            shown_q  <= 1'b0;
        end else begin
            finish_q <= finish;
            hold_q   <= hold_d;
            shown_q  <= shown_d;
        end
    end

    // Scan counters and registered display outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_POL;
            an_q    <= AN_POL;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign shown = shown_q;

endmodule
